// File: rtl/branch_predictor_pkg.sv
// Shared encodings and constants for the KGP-RISC fetch-side branch predictor.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package kgp_bp_pkg;

  // 2-bit saturating counter states; MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam logic [1:0]  BHT_RESET = WNT;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Sequential successor of a branch, wrapping at the top of the address space.
  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/branch_predictor_counter_update.sv
// 2-bit saturating counter next-state: up on taken, down on not-taken, clamped at the ends.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is written.
module bp_counter_update
  import kgp_bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  // Step one state toward the observed outcome, holding at SNT/ST.
  always_comb begin
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: combinational BHT lookup for IF, training and redirect from EX.
// Latency: prediction 0 cycles; flush/redirect one cycle after a mispredicting resolution.
// Backpressure: none; resolutions arriving while flush is high are wrong-path and dropped.
module branch_predictor
  import kgp_bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_target,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bht_q [ENTRIES];
  logic [1:0]          bht_d [ENTRIES];
  logic                flush_q, flush_d;
  logic [31:0]         redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]    branch_count_q, branch_count_d;
  logic [CNT_W-1:0]    mispredict_count_q, mispredict_count_d;

  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic                accepted;
  logic                mispredict;
  logic [1:0]          res_cnt_cur;
  logic [1:0]          res_cnt_nxt;

  // Word-aligned PCs: byte offset and bits above the table index do not select an entry.
  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign res_idx   = res_pc[IDX_BITS+1:2];

  // The cycle after a mispredict carries a wrong-path instruction in EX; ignore it.
  assign accepted   = res_valid & ~flush_q;
  assign mispredict = accepted & (res_taken != res_pred_taken);

  // Read-old: the prediction comes from the registered table, so a same-cycle write shows next cycle.
  assign pred_taken = bht_q[fetch_idx][1];

  assign res_cnt_cur = bht_q[res_idx];

  bp_counter_update u_cnt_update (
    .cur   (res_cnt_cur),
    .taken (res_taken),
    .nxt   (res_cnt_nxt)
  );

  // Table training: only the resolved entry moves, and only for accepted resolutions.
  always_comb begin
    bht_d = bht_q;
    if (accepted) begin
      bht_d[res_idx] = res_cnt_nxt;
    end
  end

  // Flush pulse, redirect target and statistics for the next cycle.
  always_comb begin
    flush_d            = mispredict;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (mispredict) begin
      redirect_pc_d      = res_taken ? res_target : fallthrough_pc(res_pc);
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
    if (accepted) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any pending flush and reinitialises the whole table at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= BHT_RESET;
      end
      flush_q            <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      flush_q            <= flush_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  // Fetch PC bits outside the index field have no effect on the lookup.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a per-cycle flush/redirect scoreboard.
// Latency: stimulus pushes the expected post-edge outputs; the monitor pops them after each edge.
// Backpressure: n/a.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic        res_pred_taken;
  logic [31:0] res_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  typedef struct {
    logic        f;
    logic [31:0] r;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;

  branch_predictor #(.IDX_BITS(6), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_taken        (res_taken),
    .res_pred_taken   (res_pred_taken),
    .res_target       (res_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, record what flush/redirect must be after the next rising edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic t, input logic p,
                     input logic [31:0] tgt, input logic [31:0] fpc,
                     input logic ef, input logic [31:0] er);
    exp_t e;
    @(negedge clk);
    res_valid      = v;
    res_pc         = pc;
    res_taken      = t;
    res_pred_taken = p;
    res_target     = tgt;
    fetch_pc       = fpc;
    e.f = ef;
    e.r = er;
    q.push_back(e);
    #1;
  endtask

  // Monitor: after every rising edge compare the registered outputs against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_flush", {31'd0, flush}, {31'd0, e.f});
      chk("sb_redirect", redirect_pc, e.r);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    res_valid = 1'b0;
    res_pc = '0;
    res_taken = 1'b0;
    res_pred_taken = 1'b0;
    res_target = '0;
    fetch_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_bcnt", branch_count, 32'd0);
    chk("rst_mcnt", mispredict_count, 32'd0);
    chk("rst_pred0", {31'd0, pred_taken}, 32'd0);
    rst = 1'b0;

    // Taken mispredict at 0x10 -> redirect to target, entry 4 becomes WT.
    cyc(1, 32'h10, 1, 0, 32'h80, 32'h10, 1, 32'h80);
    chk("t2_pred_before", {31'd0, pred_taken}, 32'd0);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h10, 0, 32'h80);
    chk("t2_pred_after", {31'd0, pred_taken}, 32'd1);
    chk("t2_bcnt", branch_count, 32'd1);
    chk("t2_mcnt", mispredict_count, 32'd1);

    // Not-taken at 0x20 four times: saturates at SNT, no flush.
    cyc(1, 32'h20, 0, 0, 32'h200, 32'h20, 0, 32'h80);
    cyc(1, 32'h20, 0, 0, 32'h200, 32'h20, 0, 32'h80);
    cyc(1, 32'h20, 0, 0, 32'h200, 32'h20, 0, 32'h80);
    cyc(1, 32'h20, 0, 0, 32'h200, 32'h20, 0, 32'h80);
    chk("t3_bcnt_three_more", branch_count, 32'd4);
    chk("t3_pred", {31'd0, pred_taken}, 32'd0);
    // One taken from SNT must land on WNT (still predicts not-taken).
    cyc(1, 32'h20, 1, 0, 32'h200, 32'h20, 1, 32'h200);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h20, 0, 32'h200);
    chk("t3_sat_low", {31'd0, pred_taken}, 32'd0);
    chk("t3_bcnt", branch_count, 32'd6);
    chk("t3_mcnt", mispredict_count, 32'd2);

    // Not-taken mispredicts: fall-through redirect, including address wrap.
    cyc(1, 32'h30, 0, 1, 32'h300, 32'h30, 1, 32'h34);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h30, 0, 32'h34);
    cyc(1, 32'hFFFF_FFFC, 0, 1, 32'h1234, 32'h30, 1, 32'h0);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h30, 0, 32'h0);
    chk("t4_bcnt", branch_count, 32'd8);
    chk("t4_mcnt", mispredict_count, 32'd4);

    // Same-cycle read and write of entry 0x11: old value this cycle, new value next cycle.
    cyc(1, 32'h44, 1, 1, 32'h500, 32'h44, 0, 32'h0);
    chk("t5_read_old", {31'd0, pred_taken}, 32'd0);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h44, 0, 32'h0);
    chk("t5_read_new", {31'd0, pred_taken}, 32'd1);

    // Mispredict followed by a wrong-path mispredict during the flush cycle.
    cyc(1, 32'h50, 1, 0, 32'h600, 32'h50, 1, 32'h600);
    cyc(1, 32'h60, 1, 0, 32'h700, 32'h60, 0, 32'h600);
    chk("t6_flush_high", {31'd0, flush}, 32'd1);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h60, 0, 32'h600);
    chk("t6_no_train", {31'd0, pred_taken}, 32'd0);
    chk("t6_bcnt", branch_count, 32'd10);
    chk("t6_mcnt", mispredict_count, 32'd5);

    // Aliasing: 0x104 trains the entry that 0x04 reads.
    cyc(1, 32'h104, 1, 1, 32'h900, 32'h04, 0, 32'h600);
    chk("t7_alias_before", {31'd0, pred_taken}, 32'd0);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h04, 0, 32'h600);
    chk("t7_alias_after", {31'd0, pred_taken}, 32'd1);

    // Drive 0x40 to ST and beyond, then one not-taken mispredict.
    cyc(1, 32'h40, 1, 1, 32'h0, 32'h40, 0, 32'h600);
    cyc(1, 32'h40, 1, 1, 32'h0, 32'h40, 0, 32'h600);
    cyc(1, 32'h40, 1, 1, 32'h0, 32'h40, 0, 32'h600);
    cyc(1, 32'h40, 0, 1, 32'h0, 32'h40, 1, 32'h44);
    chk("t8_pred_st", {31'd0, pred_taken}, 32'd1);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h40, 0, 32'h44);
    chk("t8_pred_wt", {31'd0, pred_taken}, 32'd1);
    chk("t8_flush_high", {31'd0, flush}, 32'd1);
    chk("t8_bcnt", branch_count, 32'd15);
    chk("t8_mcnt", mispredict_count, 32'd6);

    // Reset mid-flush: everything clears immediately, without a clock edge.
    rst = 1'b1;
    #1;
    chk("t1_flush_drop", {31'd0, flush}, 32'd0);
    chk("t1_redirect", redirect_pc, 32'h0);
    chk("t1_bcnt", branch_count, 32'd0);
    chk("t1_mcnt", mispredict_count, 32'd0);
    fetch_pc = 32'h0;
    #1;
    chk("t1_pred_00", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h40;
    #1;
    chk("t1_pred_40", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'hFC;
    #1;
    chk("t1_pred_fc", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h10;
    #1;
    chk("t1_pred_10", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle cycles after reset must not produce a flush.
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #2;
    chk("sb_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
